// File: rtl/serial_pkg.sv
// Shared constants for the serial output path: byte width, TX queue depth
// and requester indices used by the serial_tx_arbiter.
package serial_pkg;

    localparam int SERIAL_W      = 8;
    localparam int TX_FIFO_DEPTH = 4;

    localparam int REQ_CPU = 0;
    localparam int REQ_DBG = 1;

    typedef enum logic {
        GRANT_CPU = 1'b0,
        GRANT_DBG = 1'b1
    } grant_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read (pop_data shows the oldest
// entry) and an occupancy count; push on full and pop on empty are ignored.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; pointers and count alone define which entries are valid.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter sharing the serial output port between the CPU store
// path and the debug printer, with a small queue and registered output strobe.
module serial_tx_arbiter
    import serial_pkg::*;
#(
    parameter int DATA_W = SERIAL_W,
    parameter int DEPTH  = TX_FIFO_DEPTH,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              serial_ready_in,
    output logic [DATA_W-1:0] serial_out,
    output logic              serial_wren_out,
    output logic [CNT_W-1:0]  fifo_count,
    output logic              idle
);

    logic [1:0]        valid;
    logic [1:0]        grant;
    grant_e            last_grant;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] push_data;
    logic [DATA_W-1:0] head_data;
    logic              full;
    logic              empty;

    assign valid[REQ_CPU] = req0_valid;
    assign valid[REQ_DBG] = req1_valid;

    // NOTE: grant gets its default before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        grant = '0;
        if (!reset && !full) begin
            if (valid[REQ_CPU] && valid[REQ_DBG]) begin
                if (last_grant == GRANT_CPU) grant[REQ_DBG] = 1'b1;
                else                         grant[REQ_CPU] = 1'b1;
            end else begin
                grant = valid;
            end
        end
    end

    assign req0_ready = grant[REQ_CPU];
    assign req1_ready = grant[REQ_DBG];
    assign push       = |grant;
    assign push_data  = grant[REQ_DBG] ? req1_data : req0_data;
    // No pass-through: a byte pushed this edge is only poppable from the next edge on.
    assign pop        = !reset && !empty && serial_ready_in;

    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant      <= GRANT_DBG;
            serial_out      <= '0;
            serial_wren_out <= 1'b0;
        end else begin
            if (push) last_grant <= grant[REQ_DBG] ? GRANT_DBG : GRANT_CPU;
            if (pop) begin
                serial_out      <= head_data;
                serial_wren_out <= 1'b1;
            end else begin
                serial_wren_out <= 1'b0;
            end
        end
    end

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (head_data),
        .count     (fifo_count),
        .full      (full),
        .empty     (empty)
    );

    assign idle = (fifo_count == '0) && !serial_wren_out;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Testbench for serial_tx_arbiter: hand-derived vector table, directed
// multi-cycle corner cases, then randomized traffic against a queue model.
module tb_serial_tx_arbiter;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clock;
    logic          reset;
    logic          req0_valid;
    logic [DW-1:0] req0_data;
    logic          req0_ready;
    logic          req1_valid;
    logic [DW-1:0] req1_data;
    logic          req1_ready;
    logic          serial_ready_in;
    logic [DW-1:0] serial_out;
    logic          serial_wren_out;
    logic [CW-1:0] fifo_count;
    logic          idle;

    int n_checks = 0;
    int n_pass   = 0;

    serial_tx_arbiter dut (
        .clock           (clock),
        .reset           (reset),
        .req0_valid      (req0_valid),
        .req0_data       (req0_data),
        .req0_ready      (req0_ready),
        .req1_valid      (req1_valid),
        .req1_data       (req1_data),
        .req1_ready      (req1_ready),
        .serial_ready_in (serial_ready_in),
        .serial_out      (serial_out),
        .serial_wren_out (serial_wren_out),
        .fifo_count      (fifo_count),
        .idle            (idle)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic          rst;
        logic          v0;
        logic [DW-1:0] d0;
        logic          v1;
        logic [DW-1:0] d1;
        logic          rdy;
        logic          r0;
        logic          r1;
        logic          wren;
        logic [DW-1:0] out;
        int            cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(input logic rst, input logic v0, input logic [DW-1:0] d0,
                                    input logic v1, input logic [DW-1:0] d1, input logic rdy,
                                    input logic r0, input logic r1, input logic wren,
                                    input logic [DW-1:0] out, input int cnt);
        vec_t v;
        v.rst = rst; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.rdy = rdy;
        v.r0 = r0; v.r1 = r1; v.wren = wren; v.out = out; v.cnt = cnt;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Apply inputs just after the falling edge; outputs are then sampled 1 time unit later.
    task automatic drive(input logic rst, input logic v0, input logic [DW-1:0] d0,
                         input logic v1, input logic [DW-1:0] d1, input logic rdy);
        @(negedge clock);
        reset           = rst;
        req0_valid      = v0;
        req0_data       = d0;
        req1_valid      = v1;
        req1_data       = d1;
        serial_ready_in = rdy;
        #1;
    endtask

    // Reference model state
    logic [DW-1:0] mq[$];
    int            m_last;
    logic [DW-1:0] m_out;
    logic          m_wren;

    initial begin
        logic [DW-1:0] got[$];
        int            next_b;
        logic          pend0, pend1, rst_r, rdy_r;
        logic [DW-1:0] dat0, dat1;
        int            win;

        reset = 1'b1; req0_valid = 1'b1; req0_data = 8'h48;
        req1_valid = 1'b0; req1_data = '0; serial_ready_in = 1'b0;

        // Reset held with req0 valid
        add_vec(1, 1, 8'h48, 0, 8'h00, 0,  0, 0, 0, 8'h00, 0);
        add_vec(1, 1, 8'h48, 0, 8'h00, 0,  0, 0, 0, 8'h00, 0);
        add_vec(1, 1, 8'h48, 0, 8'h00, 1,  0, 0, 0, 8'h00, 0);
        // Single byte 'H': accepted, strobe two cycles later
        add_vec(0, 1, 8'h48, 0, 8'h00, 1,  1, 0, 0, 8'h00, 0);
        add_vec(0, 0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 8'h00, 1);
        add_vec(0, 0, 8'h00, 0, 8'h00, 1,  0, 0, 1, 8'h48, 0);
        add_vec(0, 0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 8'h48, 0);
        // Reset restores last_grant, then both requesters contend
        add_vec(1, 0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 8'h48, 0);
        add_vec(0, 1, 8'h41, 1, 8'h78, 1,  1, 0, 0, 8'h00, 0);
        add_vec(0, 1, 8'h42, 1, 8'h78, 1,  0, 1, 0, 8'h00, 1);
        add_vec(0, 1, 8'h42, 1, 8'h79, 1,  1, 0, 1, 8'h41, 1);
        add_vec(0, 0, 8'h00, 1, 8'h79, 1,  0, 1, 1, 8'h78, 1);
        add_vec(0, 0, 8'h00, 0, 8'h00, 1,  0, 0, 1, 8'h42, 1);
        add_vec(0, 0, 8'h00, 0, 8'h00, 1,  0, 0, 1, 8'h79, 0);
        add_vec(0, 0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 8'h79, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].v0, vecs[i].d0, vecs[i].v1, vecs[i].d1, vecs[i].rdy);
            check($sformatf("vec%0d_req0_ready", i), 32'(req0_ready), 32'(vecs[i].r0));
            check($sformatf("vec%0d_req1_ready", i), 32'(req1_ready), 32'(vecs[i].r1));
            check($sformatf("vec%0d_wren", i), 32'(serial_wren_out), 32'(vecs[i].wren));
            check($sformatf("vec%0d_out", i), 32'(serial_out), 32'(vecs[i].out));
            check($sformatf("vec%0d_count", i), 32'(fifo_count), 32'(vecs[i].cnt));
            check($sformatf("vec%0d_idle", i), 32'(idle),
                  32'((vecs[i].cnt == 0) && !vecs[i].wren));
        end

        // Sink stalled: four bytes fill the queue, then req0 is held off
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 1, 8'(i + 1), 0, 8'h00, 0);
            check("fill_req0_ready", 32'(req0_ready), 32'd1);
            check("fill_count", 32'(fifo_count), 32'(i));
        end
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 8'h05, 0, 8'h00, 0);
            check("full_req0_ready", 32'(req0_ready), 32'd0);
            check("full_count", 32'(fifo_count), 32'(DEPTH));
        end
        next_b = 5;
        got.delete();
        for (int cyc = 0; cyc < 40 && got.size() < 6; cyc++) begin
            drive(0, next_b <= 6, 8'(next_b), 0, 8'h00, 1);
            if (serial_wren_out) got.push_back(serial_out);
            if (req0_ready && next_b <= 6) next_b++;
        end
        check("drain_bytes_seen", 32'(got.size()), 32'd6);
        for (int i = 0; i < got.size(); i++)
            check($sformatf("drain_byte%0d", i), 32'(got[i]), 32'(i + 1));
        check("drain_final_count", 32'(fifo_count), 32'd0);

        // Full queue with sink ready: pop frees a slot, push waits one cycle
        drive(1, 0, 8'h00, 0, 8'h00, 0);
        for (int i = 0; i < DEPTH; i++) drive(0, 1, 8'(8'h10 + i), 0, 8'h00, 0);
        drive(0, 0, 8'h00, 1, 8'hA5, 1);
        check("pop_full_req1_ready", 32'(req1_ready), 32'd0);
        check("pop_full_count", 32'(fifo_count), 32'(DEPTH));
        drive(0, 0, 8'h00, 1, 8'hA5, 0);
        check("after_pop_req1_ready", 32'(req1_ready), 32'd1);
        check("after_pop_count", 32'(fifo_count), 32'(DEPTH - 1));
        check("after_pop_wren", 32'(serial_wren_out), 32'd1);
        check("after_pop_out", 32'(serial_out), 32'h10);
        drive(0, 0, 8'h00, 0, 8'h00, 0);
        check("refill_count", 32'(fifo_count), 32'(DEPTH));
        check("refill_wren", 32'(serial_wren_out), 32'd0);

        // Mid-operation reset discards queued bytes
        drive(1, 0, 8'h00, 0, 8'h00, 0);
        drive(0, 1, 8'h21, 0, 8'h00, 0);
        drive(0, 1, 8'h22, 0, 8'h00, 0);
        drive(1, 0, 8'h00, 0, 8'h00, 1);
        check("pre_reset_count", 32'(fifo_count), 32'd2);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 8'h00, 0, 8'h00, 1);
            check("post_reset_count", 32'(fifo_count), 32'd0);
            check("post_reset_wren", 32'(serial_wren_out), 32'd0);
            check("post_reset_out", 32'(serial_out), 32'd0);
        end
        drive(0, 1, 8'h55, 0, 8'h00, 1);
        check("new_byte_ready", 32'(req0_ready), 32'd1);
        drive(0, 0, 8'h00, 0, 8'h00, 1);
        check("new_byte_wren_early", 32'(serial_wren_out), 32'd0);
        drive(0, 0, 8'h00, 0, 8'h00, 1);
        check("new_byte_wren", 32'(serial_wren_out), 32'd1);
        check("new_byte_out", 32'(serial_out), 32'h55);

        // Randomized traffic against the queue model
        drive(1, 0, 8'h00, 0, 8'h00, 0);
        mq.delete(); m_last = 1; m_out = '0; m_wren = 1'b0;
        pend0 = 1'b0; pend1 = 1'b0; dat0 = '0; dat1 = '0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            rst_r = ($urandom_range(0, 99) == 0);
            if (!pend0 && $urandom_range(0, 1) == 1) begin pend0 = 1'b1; dat0 = 8'($urandom); end
            if (!pend1 && $urandom_range(0, 1) == 1) begin pend1 = 1'b1; dat1 = 8'($urandom); end
            if ((cyc / 50) % 3 == 0) rdy_r = ($urandom_range(0, 9) == 0);
            else                     rdy_r = ($urandom_range(0, 3) != 0);
            drive(rst_r, pend0, dat0, pend1, dat1, rdy_r);

            win = -1;
            if (!rst_r && mq.size() < DEPTH) begin
                if (pend0 && pend1) win = (m_last == 0) ? 1 : 0;
                else if (pend0)     win = 0;
                else if (pend1)     win = 1;
            end
            check("rnd_req0_ready", 32'(req0_ready), 32'(win == 0));
            check("rnd_req1_ready", 32'(req1_ready), 32'(win == 1));
            check("rnd_count", 32'(fifo_count), 32'(mq.size()));
            check("rnd_wren", 32'(serial_wren_out), 32'(m_wren));
            check("rnd_out", 32'(serial_out), 32'(m_out));
            check("rnd_idle", 32'(idle), 32'(mq.size() == 0 && !m_wren));

            if (rst_r) begin
                mq.delete(); m_last = 1; m_out = '0; m_wren = 1'b0;
            end else begin
                if (mq.size() > 0 && rdy_r) begin
                    m_out  = mq.pop_front();
                    m_wren = 1'b1;
                end else begin
                    m_wren = 1'b0;
                end
                if (win == 0) begin mq.push_back(dat0); pend0 = 1'b0; m_last = 0; end
                if (win == 1) begin mq.push_back(dat1); pend1 = 1'b0; m_last = 1; end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
